sparse_tile_scheduler: RTL and testbench
========================================

// Module: sparse_tile_scheduler
// PURPOSE
// Hardware loop-nest controller for the sparse_accelerator PE array; output-activation stationary.
// Per OA column m and row tile j: issues one load per weight column tile i, waits all_finished,
// then flushes, captures the W_ROW results, clears the accumulators and writes back via a
// valid/ready port. New vs. the bench-driven flow: skip of all-zero tiles, back-pressure, abort, perf counters.
// PARAMETERS
// W_ROW        16    rows per weight tile (= results per capture)
// W_COL        8     cols per weight tile (= activations per load)
// BW_ACT       8     result width per row
// N_ROW_TILES  8     Weight_H/W_ROW tiles, >=1
// N_COL_TILES  72    Weight_W/W_COL tiles, >=1
// N_OA_COLS    1024  output activation columns, >=1
// BW_CNT       32    perf counter width
// PORTS
// clk            in   1               clock
// reset          in   1               asynchronous, active-high reset
// start          in   1               pulse; accepted only in IDLE
// abort          in   1               sync abort; any state -> IDLE
// busy           out  1               high in all states except IDLE
// done           out  1               one-cycle pulse after last write-back
// ld_valid       out  1               tile load request
// ld_ready       in   1               upstream has W/P/Z/act for (ld_row_tile,ld_col_tile,ld_oa_col)
// ld_skip        in   1               with ld_ready: tile all-zero, do not load into PEs
// ld_row_tile    out  $clog2(N_ROW_TILES)+1  j
// ld_col_tile    out  $clog2(N_COL_TILES)+1  i
// ld_oa_col      out  $clog2(N_OA_COLS)+1    m
// acc_load       out  1               one-cycle strobe: accelerator samples W/P/Z/act
// acc_mac_enable out  1               = busy
// acc_clear_acc  out  1               one-cycle accumulator clear
// acc_all_finished in 1               accelerator idle/drained
// acc_result     in   W_ROW*BW_ACT    row n at [n*BW_ACT +: BW_ACT]
// wr_valid       out  1               write-back valid
// wr_ready       in   1               write-back accept
// wr_data        out  W_ROW*BW_ACT    captured results, stable while wr_valid
// wr_row_base    out  $clog2(N_ROW_TILES*W_ROW)+1  j*W_ROW
// wr_col         out  $clog2(N_OA_COLS)+1          m
// perf_cycles    out  BW_CNT          cycles busy since start (saturating)
// perf_skipped   out  BW_CNT          tiles skipped since start (saturating)
// BEHAVIOUR
// - Reset: state IDLE, i=j=m=0; every output 0 (wr_data, perf counters included).
// - States: IDLE, LOAD, WAIT, FLUSH, CAPTURE, WRITE, DONE.
// - IDLE: start -> i=j=m=0, perf counters cleared, -> LOAD.
// - LOAD: ld_valid=1, indices stable until ld_ready. On ld_ready&~ld_skip: acc_load=1 that cycle, -> WAIT.
//   On ld_ready&ld_skip: no acc_load, perf_skipped++; if i<N_COL_TILES-1 then i++ and stay LOAD, else -> FLUSH.
// - WAIT: acc_all_finished ignored during the first cycle after acc_load (pipeline fill).
//   From cycle 2 on, when high: if i<N_COL_TILES-1 then i++ -> LOAD, else -> FLUSH.
// - FLUSH: empty slot (no load) for the last tile. Hold 1 cycle, then wait acc_all_finished=1 -> CAPTURE.
// - CAPTURE: wr_data<=acc_result, acc_clear_acc=1 for exactly this cycle, -> WRITE.
// - WRITE: wr_valid=1; wr_data, wr_row_base and wr_col held until wr_ready.
//   On accept: i=0, then j++. When j wraps: j=0, m++.
//   After the final (j=N_ROW_TILES-1, m=N_OA_COLS-1) accept -> DONE; otherwise -> LOAD.
// - DONE: done=1 for one cycle, -> IDLE; perf counters hold their values until the next start.
// - All tiles skipped for a (j,m): FLUSH/CAPTURE still run, so zeros are written.
// - abort (priority over all but reset): next state IDLE, acc_clear_acc=1 one cycle, ld_valid/wr_valid drop, no done.
// - start while busy: ignored. start with abort in the same cycle: abort wins.
// - Async reset mid-operation: immediate return to reset values; no clear pulse is emitted.
// - perf_cycles counts every non-IDLE cycle. Both counters saturate at 2^BW_CNT-1.
// TESTING (bench params: N_ROW_TILES=2, N_COL_TILES=3, N_OA_COLS=2; accelerator model finishes 4 cycles after acc_load)
// 1 start, ld_ready=wr_ready=1, no skip -> 12 acc_load, 4 writes in order
//   (row_base,col) = (0,0),(16,0),(0,1),(16,1); done once; wr_data matches golden sums.
// 2 ld_skip=1 for i=1 on every (j,m) -> 8 acc_load, perf_skipped=4; results equal the reference with tile 1 zeroed.
// 3 wr_ready low 10 cycles on first write -> wr_valid/wr_data stable 10 cycles;
//   no acc_load until accepted; perf_cycles grows by 10 vs. scenario 1.
// 4 abort during WAIT of (j=1,m=0,i=2) -> next cycle IDLE, busy=0, one acc_clear_acc, no done;
//   a fresh start then completes as scenario 1.
// 5 reset asserted in WRITE -> all outputs 0 immediately; start after reset gives scenario 1 results.
// 6 all ld_skip=1 -> zero acc_load, 4 writes of all-zero data, perf_skipped=12, done pulses.

Source files
------------

// File: rtl/sparse_tile_scheduler.sv
// Loop-nest controller for the sparse PE array: walks (m, j, i) tiles, loads or skips each one,
// flushes, captures the row results and writes them back over a valid/ready port.
module sparse_tile_scheduler #(
    parameter int unsigned W_ROW       = 16,
    parameter int unsigned W_COL       = 8,
    parameter int unsigned BW_ACT      = 8,
    parameter int unsigned N_ROW_TILES = 8,
    parameter int unsigned N_COL_TILES = 72,
    parameter int unsigned N_OA_COLS   = 1024,
    parameter int unsigned BW_CNT      = 32
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic                                       abort,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       ld_valid,
    input  logic                                       ld_ready,
    input  logic                                       ld_skip,
    output logic [$clog2(N_ROW_TILES)-1+1:0]           ld_row_tile,
    output logic [$clog2(N_COL_TILES)-1+1:0]           ld_col_tile,
    output logic [$clog2(N_OA_COLS)-1+1:0]             ld_oa_col,
    output logic                                       acc_load,
    output logic                                       acc_mac_enable,
    output logic                                       acc_clear_acc,
    input  logic                                       acc_all_finished,
    input  logic [W_ROW*BW_ACT-1:0]                    acc_result,
    output logic                                       wr_valid,
    input  logic                                       wr_ready,
    output logic [W_ROW*BW_ACT-1:0]                    wr_data,
    output logic [$clog2(N_ROW_TILES*W_ROW)-1+1:0]     wr_row_base,
    output logic [$clog2(N_OA_COLS)-1+1:0]             wr_col,
    output logic [BW_CNT-1:0]                          perf_cycles,
    output logic [BW_CNT-1:0]                          perf_skipped
);

    localparam int unsigned RI_W = $clog2(N_ROW_TILES) + 1;
    localparam int unsigned CI_W = $clog2(N_COL_TILES) + 1;
    localparam int unsigned MI_W = $clog2(N_OA_COLS) + 1;
    localparam int unsigned RB_W = $clog2(N_ROW_TILES * W_ROW) + 1;

    if (N_ROW_TILES < 1 || N_COL_TILES < 1 || N_OA_COLS < 1 || W_ROW < 1 || W_COL < 1 ||
        BW_ACT < 1 || BW_CNT < 1) begin : g_bad_params
        $error("sparse_tile_scheduler: all size parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StFlush,
        StCapture,
        StWrite,
        StDone
    } state_e;

    state_e                    state_q, state_d;
    logic [CI_W-1:0]           i_q, i_d;
    logic [RI_W-1:0]           j_q, j_d;
    logic [MI_W-1:0]           m_q, m_d;
    // Set on entry to WAIT/FLUSH so the first cycle ignores a stale acc_all_finished.
    logic                      first_q, first_d;
    logic [W_ROW*BW_ACT-1:0]   wr_data_q, wr_data_d;
    logic [BW_CNT-1:0]         cycles_q, cycles_d;
    logic [BW_CNT-1:0]         skipped_q, skipped_d;

    logic                      last_i, last_j, last_m;
    logic [BW_CNT-1:0]         cycles_inc;
    logic [BW_CNT-1:0]         skipped_inc;

    assign last_i = (i_q == CI_W'(N_COL_TILES - 1));
    assign last_j = (j_q == RI_W'(N_ROW_TILES - 1));
    assign last_m = (m_q == MI_W'(N_OA_COLS - 1));

    always_comb begin
        cycles_inc = cycles_q;
        if (state_q != StIdle && cycles_q != '1) begin
            cycles_inc = cycles_q + BW_CNT'(1);
        end
        skipped_inc = skipped_q;
        if (skipped_q != '1) begin
            skipped_inc = skipped_q + BW_CNT'(1);
        end
    end

    always_comb begin
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        m_d           = m_q;
        first_d       = 1'b0;
        wr_data_d     = wr_data_q;
        cycles_d      = cycles_inc;
        skipped_d     = skipped_q;
        acc_load      = 1'b0;
        acc_clear_acc = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    i_d       = '0;
                    j_d       = '0;
                    m_d       = '0;
                    cycles_d  = '0;
                    skipped_d = '0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                if (ld_ready) begin
                    if (!ld_skip) begin
                        acc_load = 1'b1;
                        first_d  = 1'b1;
                        state_d  = StWait;
                    end else begin
                        skipped_d = skipped_inc;
                        if (last_i) begin
                            first_d = 1'b1;
                            state_d = StFlush;
                        end else begin
                            i_d = i_q + CI_W'(1);
                        end
                    end
                end
            end
            StWait: begin
                if (!first_q && acc_all_finished) begin
                    if (last_i) begin
                        first_d = 1'b1;
                        state_d = StFlush;
                    end else begin
                        i_d     = i_q + CI_W'(1);
                        state_d = StLoad;
                    end
                end
            end
            StFlush: begin
                if (!first_q && acc_all_finished) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                wr_data_d     = acc_result;
                acc_clear_acc = 1'b1;
                state_d       = StWrite;
            end
            StWrite: begin
                if (wr_ready) begin
                    i_d = '0;
                    if (last_j) begin
                        j_d = '0;
                        if (last_m) begin
                            m_d     = '0;
                            state_d = StDone;
                        end else begin
                            m_d     = m_q + MI_W'(1);
                            state_d = StLoad;
                        end
                    end else begin
                        j_d     = j_q + RI_W'(1);
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides everything decided above, including a same-cycle start.
        if (abort) begin
            state_d       = StIdle;
            i_d           = '0;
            j_d           = '0;
            m_d           = '0;
            first_d       = 1'b0;
            wr_data_d     = wr_data_q;
            cycles_d      = cycles_inc;
            skipped_d     = skipped_q;
            acc_load      = 1'b0;
            acc_clear_acc = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            i_q       <= '0;
            j_q       <= '0;
            m_q       <= '0;
            first_q   <= 1'b0;
            wr_data_q <= '0;
            cycles_q  <= '0;
            skipped_q <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            m_q       <= m_d;
            first_q   <= first_d;
            wr_data_q <= wr_data_d;
            cycles_q  <= cycles_d;
            skipped_q <= skipped_d;
        end
    end

    assign busy           = (state_q != StIdle);
    assign done           = (state_q == StDone);
    assign ld_valid       = (state_q == StLoad);
    assign wr_valid       = (state_q == StWrite);
    assign acc_mac_enable = busy;
    assign ld_row_tile    = j_q;
    assign ld_col_tile    = i_q;
    assign ld_oa_col      = m_q;
    assign wr_data        = wr_data_q;
    assign wr_row_base    = RB_W'(j_q) * RB_W'(W_ROW);
    assign wr_col         = m_q;
    assign perf_cycles    = cycles_q;
    assign perf_skipped   = skipped_q;

endmodule

// File: tb/tb_sparse_tile_scheduler.sv
// Directed bench for sparse_tile_scheduler with a small accumulating accelerator model
// that raises acc_all_finished four cycles after each acc_load.
module tb_sparse_tile_scheduler;

    localparam int NR   = 2;
    localparam int NC   = 3;
    localparam int NM   = 2;
    localparam int WR   = 16;
    localparam int BA   = 8;
    localparam int BC   = 32;
    localparam int RI_W = $clog2(NR) + 1;
    localparam int CI_W = $clog2(NC) + 1;
    localparam int MI_W = $clog2(NM) + 1;
    localparam int RB_W = $clog2(NR * WR) + 1;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_skip;
    logic [RI_W-1:0]   ld_row_tile;
    logic [CI_W-1:0]   ld_col_tile;
    logic [MI_W-1:0]   ld_oa_col;
    logic              acc_load;
    logic              acc_mac_enable;
    logic              acc_clear_acc;
    logic              acc_all_finished;
    logic [WR*BA-1:0]  acc_result;
    logic              wr_valid;
    logic              wr_ready;
    logic [WR*BA-1:0]  wr_data;
    logic [RB_W-1:0]   wr_row_base;
    logic [MI_W-1:0]   wr_col;
    logic [BC-1:0]     perf_cycles;
    logic [BC-1:0]     perf_skipped;

    sparse_tile_scheduler #(
        .W_ROW       (WR),
        .W_COL       (8),
        .BW_ACT      (BA),
        .N_ROW_TILES (NR),
        .N_COL_TILES (NC),
        .N_OA_COLS   (NM),
        .BW_CNT      (BC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .busy             (busy),
        .done             (done),
        .ld_valid         (ld_valid),
        .ld_ready         (ld_ready),
        .ld_skip          (ld_skip),
        .ld_row_tile      (ld_row_tile),
        .ld_col_tile      (ld_col_tile),
        .ld_oa_col        (ld_oa_col),
        .acc_load         (acc_load),
        .acc_mac_enable   (acc_mac_enable),
        .acc_clear_acc    (acc_clear_acc),
        .acc_all_finished (acc_all_finished),
        .acc_result       (acc_result),
        .wr_valid         (wr_valid),
        .wr_ready         (wr_ready),
        .wr_data          (wr_data),
        .wr_row_base      (wr_row_base),
        .wr_col           (wr_col),
        .perf_cycles      (perf_cycles),
        .perf_skipped     (perf_skipped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contribution of tile (j,i,m) to result row n.
    function automatic logic [BA-1:0] tval(input int j, input int i, input int m, input int n);
        return BA'((j * 16 + n) + i * 3 + m * 7 + 1);
    endfunction

    // mode 0: no skips, 1: tile i=1 skipped, 2: all tiles skipped.
    function automatic logic [127:0] golden(input int j, input int m, input int mode);
        logic [127:0]  r;
        logic [BA-1:0] s;
        r = '0;
        for (int n = 0; n < WR; n++) begin
            s = '0;
            for (int i = 0; i < NC; i++) begin
                if (!(mode == 2 || (mode == 1 && i == 1))) s = s + tval(j, i, m, n);
            end
            r[n*BA +: BA] = s;
        end
        return r;
    endfunction

    // Accelerator model
    logic [BA-1:0] acc [WR];
    logic [2:0]    fin_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fin_cnt <= '0;
            for (int n = 0; n < WR; n++) acc[n] <= '0;
        end else begin
            if (acc_load) fin_cnt <= 3'd3;
            else if (fin_cnt != 0) fin_cnt <= fin_cnt - 3'd1;
            for (int n = 0; n < WR; n++) begin
                if (acc_clear_acc) acc[n] <= '0;
                else if (acc_load)
                    acc[n] <= acc[n] + tval(int'(ld_row_tile), int'(ld_col_tile), int'(ld_oa_col), n);
            end
        end
    end
    assign acc_all_finished = (fin_cnt == 0);
    always_comb begin
        acc_result = '0;
        for (int n = 0; n < WR; n++) acc_result[n*BA +: BA] = acc[n];
    end

    int   skip_mode = 0;
    logic stall_en  = 1'b0;
    int   stall_seen = 0;
    assign ld_ready = 1'b1;
    always_comb ld_skip = (skip_mode == 2) || (skip_mode == 1 && ld_col_tile == CI_W'(1));
    always_comb wr_ready = !(stall_en && stall_seen < 10);
    always @(posedge clk) begin
        if (!stall_en) stall_seen <= 0;
        else if (wr_valid && !wr_ready) stall_seen <= stall_seen + 1;
    end

    // Monitor
    int           n_load = 0, n_clear = 0, n_done = 0, n_wr = 0;
    int           n_stall = 0, n_unstable = 0, n_load_stall = 0;
    logic [127:0] log_data [64];
    logic [RB_W-1:0] log_rb [64];
    logic [MI_W-1:0] log_col [64];
    logic [127:0] hold_data;
    logic [RB_W-1:0] hold_rb;
    logic [MI_W-1:0] hold_col;
    logic         prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (acc_load) n_load <= n_load + 1;
            if (acc_clear_acc) n_clear <= n_clear + 1;
            if (done) n_done <= n_done + 1;
            if (wr_valid && wr_ready && n_wr < 64) begin
                log_data[n_wr] <= wr_data;
                log_rb[n_wr]   <= wr_row_base;
                log_col[n_wr]  <= wr_col;
                n_wr           <= n_wr + 1;
            end
            if (wr_valid && !wr_ready) begin
                n_stall <= n_stall + 1;
                if (prev_stall && (wr_data != hold_data || wr_row_base != hold_rb ||
                                   wr_col != hold_col))
                    n_unstable <= n_unstable + 1;
                if (acc_load) n_load_stall <= n_load_stall + 1;
                hold_data <= wr_data;
                hold_rb   <= wr_row_base;
                hold_col  <= wr_col;
            end
            prev_stall <= wr_valid && !wr_ready;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, ".ctrl"}, {busy, done, ld_valid, acc_load, acc_mac_enable, acc_clear_acc,
                             wr_valid, ld_row_tile, ld_col_tile, ld_oa_col, wr_row_base, wr_col,
                             perf_cycles, perf_skipped}, '0);
        chk({tag, ".wr_data"}, wr_data, '0);
    endtask

    task automatic run_scn(input string name, input int mode, input int exp_cyc,
                           input int exp_skip, input int exp_loads);
        int b_load, b_done, b_wr, cyc, idx;
        skip_mode = mode;
        b_load = n_load;
        b_done = n_done;
        b_wr   = n_wr;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (n_done == b_done && cyc < 2000) begin
            step();
            cyc++;
        end
        chk({name, ".no_timeout"}, 128'(cyc < 2000), 128'(1));
        step();
        step();
        chk({name, ".done_pulses"}, 128'(n_done - b_done), 128'(1));
        chk({name, ".acc_loads"}, 128'(n_load - b_load), 128'(exp_loads));
        chk({name, ".writes"}, 128'(n_wr - b_wr), 128'(4));
        for (int k = 0; k < 4; k++) begin
            idx = b_wr + k;
            chk({name, $sformatf(".row_base%0d", k)}, 128'(log_rb[idx]), 128'((k % NR) * WR));
            chk({name, $sformatf(".col%0d", k)}, 128'(log_col[idx]), 128'(k / NR));
            chk({name, $sformatf(".data%0d", k)}, log_data[idx], golden(k % NR, k / NR, mode));
        end
        chk({name, ".perf_cycles"}, 128'(perf_cycles), 128'(exp_cyc));
        chk({name, ".perf_skipped"}, 128'(perf_skipped), 128'(exp_skip));
        chk({name, ".idle"}, 128'({busy, ld_valid, wr_valid}), 128'(0));
        skip_mode = 0;
    endtask

    initial begin
        int b_stall, b_unst, b_ls, b_clear, b_done, cyc;
        logic found;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) step();
        chk_zero_outputs("reset");
        reset = 1'b0;
        step();

        // 1: plain run, one tile per cycle budget of 5, 77 busy cycles
        run_scn("s1", 0, 77, 0, 12);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort.busy", 128'(busy), 128'(0));

        // 2: tile i=1 skipped everywhere
        run_scn("s2", 1, 61, 4, 8);

        // 3: first write stalled 10 cycles
        b_stall = n_stall;
        b_unst  = n_unstable;
        b_ls    = n_load_stall;
        stall_en = 1'b1;
        run_scn("s3", 0, 87, 0, 12);
        stall_en = 1'b0;
        chk("s3.stall_cycles", 128'(n_stall - b_stall), 128'(10));
        chk("s3.unstable", 128'(n_unstable - b_unst), 128'(0));
        chk("s3.load_in_stall", 128'(n_load_stall - b_ls), 128'(0));
        step();

        // 4: abort in WAIT of (j=1, m=0, i=2)
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            if (acc_load && ld_row_tile == 1 && ld_col_tile == 2 && ld_oa_col == 0) found = 1'b1;
            cyc++;
        end
        chk("s4.reach_wait", 128'(found), 128'(1));
        step();
        b_clear = n_clear;
        b_done  = n_done;
        abort = 1'b1;
        #1;
        chk("s4.clear_strobe", 128'(acc_clear_acc), 128'(1));
        step();
        abort = 1'b0;
        chk("s4.after_abort", 128'({busy, ld_valid, wr_valid, acc_mac_enable}), 128'(0));
        step();
        step();
        chk("s4.clear_count", 128'(n_clear - b_clear), 128'(1));
        chk("s4.no_done", 128'(n_done - b_done), 128'(0));
        run_scn("s4", 0, 77, 0, 12);

        // 5: async reset while writing (j=0, m=1)
        start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 500) begin
            if (wr_valid && wr_col == 1) found = 1'b1;
            else step();
            cyc++;
        end
        chk("s5.reach_write", 128'(found), 128'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_zero_outputs("s5.reset");
        step();
        reset = 1'b0;
        step();
        run_scn("s5", 0, 77, 0, 12);

        // 6: every tile skipped
        run_scn("s6", 2, 29, 12, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
